// File: rtl/phy_rx_deserializer.sv
// Oversampled serial-to-parallel receiver with a show-ahead output FIFO and sticky overflow.
// Optional macro PHY_RX_MAJORITY_EN selects a 2-of-3 majority bit decision around mid-bit.
module phy_rx_deserializer #(
    parameter int DATA_W     = 8,
    parameter int OSR        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_160mhz,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        RX,
    input  logic                        clr_ovf,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           RX_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int PH_W  = $clog2(OSR);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OSR / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               push_q, push_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

    logic rx_s, run, decide, bit_val;
    logic pop, full, drop, wr_en;

    assign rx_s = sync_q[1];
    // Counting starts the cycle after en is seen high and stops as soon as en drops.
    assign run  = (state_q == RUN) && en;

`ifdef PHY_RX_MAJORITY_EN
    localparam logic [PH_W-1:0] PH_PRE = PH_W'(OSR / 2 - 1);
    localparam logic [PH_W-1:0] PH_DEC = PH_W'(OSR / 2 + 1);
    logic [1:0] early_q, early_d;

    assign decide  = run && (phase_q == PH_DEC);
    assign bit_val = (early_q[1] & early_q[0]) | (early_q[1] & rx_s) | (early_q[0] & rx_s);

    always_comb begin
        early_d = early_q;
        if (!run)
            early_d = 2'b00;
        else if (phase_q == PH_PRE)
            early_d[1] = rx_s;
        else if (phase_q == PH_MID)
            early_d[0] = rx_s;
    end

    always_ff @(posedge clk_160mhz) begin
        if (!reset_n) early_q <= 2'b00;
        else          early_q <= early_d;
    end
`else
    assign decide  = run && (phase_q == PH_MID);
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d = en ? RUN : IDLE;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        if (!run) begin
            phase_d = '0;
            bit_d   = '0;
            shift_d = '0;
        end else begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            if (decide) begin
                shift_d = {shift_q[DATA_W-2:0], bit_val};
                if (bit_q == BIT_LAST) begin
                    bit_d  = '0;
                    push_d = 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
        end
    end

    assign out_valid  = (count_q != '0);
    assign RX_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

    // A push into a full FIFO still lands if the head is popped in the same cycle.
    assign pop   = out_valid && out_ready;
    assign full  = (count_q == CNT_FULL);
    assign drop  = push_q && full && !pop;
    assign wr_en = push_q && !drop;

    always_comb begin
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = drop | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk_160mhz) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            phase_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            push_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], RX};
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            push_q   <= push_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: RX_data is masked while the FIFO is empty.
    always_ff @(posedge clk_160mhz) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: queue-based reference model checked every cycle,
// plus literal expectations on popped words, counts and the overflow flag.
module tb_phy_rx_deserializer;
    localparam int DATA_W     = 8;
    localparam int OSR        = 4;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0, en = 1'b0, rx = 1'b1, clr_ovf = 1'b0, out_ready = 1'b0;
    logic out_valid, overflow;
    logic [DATA_W-1:0] rx_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phy_rx_deserializer #(.DATA_W(DATA_W), .OSR(OSR), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_160mhz(clk), .reset_n(reset_n), .en(en), .RX(rx), .clr_ovf(clr_ovf),
        .out_ready(out_ready), .out_valid(out_valid), .RX_data(rx_data),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: words are decided from the run-cycle index, FIFO is a plain queue.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] pops[$];
    logic [DATA_W-1:0] m_acc, m_pw;
    bit m_ovf, m_pend, m_enp, m_live;
    bit m_rx1, m_rx2, m_rs1, m_rs2;
    int m_k;

    initial begin
        m_live = 0;
        forever begin : mdl
            bit pop, drop, dec, b, rs;
            int ph;
            @(posedge clk);
            if (!reset_n) begin
                mq.delete();
                m_ovf = 0; m_pend = 0; m_enp = 0; m_k = 0; m_acc = '0; m_pw = '0;
                m_rx1 = 1; m_rx2 = 1; m_rs1 = 1; m_rs2 = 1;
                m_live = 1;
            end else begin
                pop  = (mq.size() != 0) && out_ready;
                drop = m_pend && (mq.size() == FIFO_DEPTH) && !pop;
                if (drop) m_ovf = 1;
                else if (clr_ovf) m_ovf = 0;
                if (pop) void'(mq.pop_front());
                if (m_pend && !drop) mq.push_back(m_pw);
                m_pend = 0;
                rs = m_rx2;
                if (m_enp && en) begin
                    ph = m_k % OSR;
`ifdef PHY_RX_MAJORITY_EN
                    dec = (ph == OSR / 2 + 1);
                    b   = (int'(m_rs2) + int'(m_rs1) + int'(rs)) >= 2;
`else
                    dec = (ph == OSR / 2);
                    b   = rs;
`endif
                    if (dec) begin
                        m_acc = {m_acc[DATA_W-2:0], b};
                        if ((m_k / OSR) % DATA_W == DATA_W - 1) begin
                            m_pend = 1;
                            m_pw   = m_acc;
                        end
                    end
                    m_k++;
                end else begin
                    m_k = 0;
                    m_acc = '0;
                end
                m_enp = en;
                m_rs2 = m_rs1; m_rs1 = rs;
                m_rx2 = m_rx1; m_rx1 = rx;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("out_valid", out_valid, mq.size() != 0);
                chk("RX_data", rx_data, (mq.size() != 0) ? mq[0] : '0);
                chk("fifo_count", fifo_count, mq.size());
                chk("overflow", overflow, m_ovf);
                if (reset_n && out_valid && out_ready) pops.push_back(rx_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the first nb bits of w MSB first; optionally forces one oversample slot to 0.
    task automatic send(input logic [DATA_W-1:0] w, input int nb, input int gb, input int gj);
        en = 1'b1;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < OSR; j++) begin
                rx = (k == gb && j == gj) ? 1'b0 : w[DATA_W-1-k];
                tick();
            end
        end
    endtask

    task automatic chk_pops(input string nm, input int n, input logic [DATA_W-1:0] e[8]);
        chk({nm, "_npop"}, pops.size(), n);
        for (int i = 0; i < n; i++)
            if (i < pops.size()) chk({nm, "_pop"}, pops[i], e[i]);
        pops.delete();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) tick();

        // Two back-to-back words, consumer always ready
        send(8'hB4, 8, -1, 0);
        send(8'hED, 8, -1, 0);
        en = 1'b0;
        repeat (4) tick();
        chk_pops("t_basic", 2, '{8'hB4, 8'hED, 0, 0, 0, 0, 0, 0});
        chk("t_basic_ovf", overflow, 0);

        // Glitch on the mid-bit sample of bit 3
        send(8'hFF, 8, 3, 1);
        en = 1'b0;
        repeat (4) tick();
`ifdef PHY_RX_MAJORITY_EN
        chk_pops("t_glitch", 1, '{8'hFF, 0, 0, 0, 0, 0, 0, 0});
`else
        chk_pops("t_glitch", 1, '{8'hEF, 0, 0, 0, 0, 0, 0, 0});
`endif

        // Overflow: five words into a stalled FIFO
        out_ready = 1'b0;
        for (int w = 1; w <= 5; w++) send(DATA_W'(w), 8, -1, 0);
        en = 1'b0;
        repeat (3) tick();
        chk("t_ovf_count", fifo_count, 4);
        chk("t_ovf_flag", overflow, 1);
        out_ready = 1'b1;
        repeat (6) tick();
        chk_pops("t_ovf", 4, '{8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0});
        chk("t_ovf_empty", fifo_count, 0);
        chk("t_ovf_sticky", overflow, 1);

        // Reset with two words held and overflow set
        out_ready = 1'b0;
        send(8'h11, 8, -1, 0);
        send(8'h12, 8, -1, 0);
        en = 1'b0;
        repeat (3) tick();
        chk("t_rst_pre_count", fifo_count, 2);
        chk("t_rst_pre_ovf", overflow, 1);
        reset_n = 1'b0;
        tick();
        chk("t_rst_valid", out_valid, 0);
        chk("t_rst_data", rx_data, 0);
        chk("t_rst_count", fifo_count, 0);
        chk("t_rst_ovf", overflow, 0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(8'h5A, 8, -1, 0);
        en = 1'b0;
        repeat (4) tick();
        chk_pops("t_rst_post", 1, '{8'h5A, 0, 0, 0, 0, 0, 0, 0});

        // Push into a full FIFO while the head is popped
        out_ready = 1'b0;
        for (int w = 0; w < 5; w++) send(DATA_W'(8'h21 + w), 8, -1, 0);
        out_ready = 1'b1;
        en = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("t_full_count", fifo_count, 4);
        chk("t_full_ovf", overflow, 0);
        out_ready = 1'b1;
        repeat (6) tick();
        chk_pops("t_full", 5, '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 0, 0, 0});

        // Partial word discarded when en drops
        send(8'hA5, 5, -1, 0);
        en = 1'b0;
        repeat (3) tick();
        send(8'h3C, 8, -1, 0);
        en = 1'b0;
        repeat (4) tick();
        chk_pops("t_abort", 1, '{8'h3C, 0, 0, 0, 0, 0, 0, 0});

        // Overflow flag clear
        out_ready = 1'b0;
        for (int w = 0; w < 5; w++) send(DATA_W'(8'h31 + w), 8, -1, 0);
        en = 1'b0;
        repeat (3) tick();
        chk("t_clr_pre", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t_clr_post", overflow, 0);
        out_ready = 1'b1;
        repeat (6) tick();
        chk_pops("t_clr", 4, '{8'h31, 8'h32, 8'h33, 8'h34, 0, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phy_rx_deserializer.md
PHY_RX_DESERIALIZER -- requirements
Module: phy_rx_deserializer

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits (SHALL be >= 2).
REQ-002 Parameter OSR, default 4, clock cycles per RX bit (SHALL be >= 4).
REQ-003 Parameter FIFO_DEPTH, default 4, output FIFO words (SHALL be a power of 2, >= 2).
REQ-004 clk_160mhz  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 en  in  1  sampling enable; a 0->1 transition defines the word boundary.
REQ-007 RX  in  1  asynchronous serial data, MSB first.
REQ-008 clr_ovf  in  1  one-cycle clear of the overflow flag.
REQ-009 out_ready  in  1  consumer accepts the head word.
REQ-010 out_valid  out  1  head word is valid.
REQ-011 RX_data  out  DATA_W  head word of the FIFO (show-ahead).
REQ-012 fifo_count  out  clog2(FIFO_DEPTH)+1  words held, 0..FIFO_DEPTH.
REQ-013 overflow  out  1  sticky: a word was dropped.

Function
REQ-014 RX SHALL pass through a 2-flop synchronizer; rx_s is the second-flop output.
REQ-015 States: IDLE (en=0) and RUN (en=1); IDLE SHALL hold the phase counter, bit counter and shift register at 0.
REQ-016 The phase counter SHALL be 0 in the first RUN cycle and SHALL wrap from OSR-1 to 0.
REQ-017 Bit decision SHALL be taken from rx_s at phase OSR/2 (integer division).
REQ-018 The shift register SHALL shift left and insert the decided bit at bit 0, so the first bit received lands at bit DATA_W-1.
REQ-019 The bit counter SHALL count 0..DATA_W-1; on the decision that completes a word, the assembled word SHALL be pushed into the FIFO in the following cycle and the bit counter SHALL return to 0.
REQ-020 out_valid SHALL rise the cycle after a push into an empty FIFO; RX_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 A pop SHALL occur on any cycle with out_valid=1 and out_ready=1; out_ready with an empty FIFO SHALL have no effect.
REQ-022 Push and pop in the same cycle SHALL leave fifo_count unchanged, including when full.
REQ-023 Push with fifo_count==FIFO_DEPTH and no pop SHALL drop the new word, leave the FIFO contents untouched, and set overflow.
REQ-024 overflow SHALL stay 1 until clr_ovf=1 or reset; if clr_ovf and a drop coincide, overflow SHALL be 1.
REQ-025 en falling mid-word SHALL discard the partial word without a push; the FIFO SHALL be unaffected.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-027 With reset_n=0 at a clock edge: out_valid=0, RX_data=0, fifo_count=0, overflow=0, synchronizer flops=1, counters and shift register=0, state IDLE.
REQ-028 reset_n=0 mid-word or mid-handshake SHALL discard all data; after release, RUN begins on the first cycle with en=1.

Configuration
REQ-029 Macro PHY_RX_MAJORITY_EN: when defined, the bit decision SHALL be the 2-of-3 majority of rx_s at phases OSR/2-1, OSR/2 and OSR/2+1, taken at phase OSR/2+1, with the push still in the cycle after that decision.
REQ-030 Without PHY_RX_MAJORITY_EN, the single sample of REQ-017 SHALL be used, and none of the majority logic SHALL be present.

Verification
REQ-031 Defaults, en=1, out_ready=1. RX drives 10110100 then 11101101, each bit held 4 cycles. Expect RX_data=0xB4 then 0xED, each with out_valid pulsed for one cycle, and overflow=0.
REQ-032 out_ready=0, 5 words 0x01..0x05 sent. Expect fifo_count=4, overflow=1, and then, with out_ready=1, pops of 0x01,0x02,0x03,0x04 only.
REQ-033 Full FIFO, out_ready=1 during the 5th push. Expect fifo_count to stay at 4, overflow=0, and 0x05 to be popped last.
REQ-034 With PHY_RX_MAJORITY_EN, bits of 0xFF with a 1-cycle 0 glitch at phase OSR/2 of bit 3. Expect 0xFF. Without the macro, expect 0xEF.
REQ-035 en drops after 5 bits of 0xA5, then a full 0x3C is sent. Expect only 0x3C to be output.
REQ-036 reset_n=0 for 1 cycle with fifo_count=2 and overflow=1. Expect all outputs 0 the next cycle, with a subsequent word output correctly.
